// File: rtl/microwire_read_capture.sv
// Captures 93C46 READ responses from the DO pin and polls DO for ready/busy
// after write-class commands, with a cycle-count timeout on the poll.
module microwire_read_capture #(
    parameter int WORD_W       = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int POLL_TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              arm_read,
    input  logic              arm_poll,
    input  logic              sample,
    input  logic              do_in,
    input  logic              ack,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              busy,
    output logic              ready,
    output logic              dummy_err,
    output logic              timeout
);

    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int TMO_W = $clog2(POLL_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DUMMY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_POLL  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   do_s;

    logic [1:0]        state_q,      state_d;
    logic [WORD_W-1:0] shift_q,      shift_d;
    logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic [WORD_W-1:0] word_out_q,   word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              busy_q,       busy_d;
    logic              ready_q,      ready_d;
    logic              dummy_err_q,  dummy_err_d;
    logic              timeout_q,    timeout_d;

    // DO synchroniser; idles high so a released bus never looks like data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], do_in};
        end
    end

    assign do_s = sync_q[SYNC_STAGES-1];

    // Next-state logic; a completing word takes priority over a same-cycle ack
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        ready_d      = 1'b0;
        dummy_err_d  = dummy_err_q;
        timeout_d    = timeout_q;

        if (ack) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm_read) begin
                    state_d     = ST_DUMMY;
                    shift_d     = {WORD_W{1'b0}};
                    bit_cnt_d   = {BIT_W{1'b0}};
                    dummy_err_d = 1'b0;
                end else if (arm_poll) begin
                    state_d   = ST_POLL;
                    tmo_cnt_d = {TMO_W{1'b0}};
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DUMMY: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    // A high dummy bit is flagged but the data is still captured
                    dummy_err_d = dummy_err_q | do_s;
                    state_d     = ST_SHIFT;
                end else begin
                    state_d = ST_DUMMY;
                end
            end
            ST_SHIFT: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    shift_d = {shift_q[WORD_W-2:0], do_s};
                    if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        word_out_d   = {shift_q[WORD_W-2:0], do_s};
                        word_valid_d = 1'b1;
                        bit_cnt_d    = {BIT_W{1'b0}};
                        state_d      = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_POLL: begin
                if (!cs) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (sample && do_s) begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tmo_cnt_d == TMO_W'(POLL_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= {WORD_W{1'b0}};
            bit_cnt_q    <= {BIT_W{1'b0}};
            tmo_cnt_q    <= {TMO_W{1'b0}};
            word_out_q   <= {WORD_W{1'b0}};
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            dummy_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            dummy_err_q  <= dummy_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign dummy_err  = dummy_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_microwire_read_capture.sv
// Directed and randomized checks of microwire_read_capture against a
// transaction-level expectation model.
module tb_microwire_read_capture;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int PT = 100;

    logic         clk = 1'b0;
    logic         rst_n, cs, arm_read, arm_poll, sample, do_in, ack;
    logic [W-1:0] word_out;
    logic         word_valid, busy, ready, dummy_err, timeout;

    int checks = 0;
    int errors = 0;
    int ready_seen = 0;

    logic [W-1:0] exp_word;
    logic         exp_valid, exp_derr;

    microwire_read_capture #(
        .WORD_W(W), .SYNC_STAGES(SS), .POLL_TIMEOUT(PT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .arm_read(arm_read),
        .arm_poll(arm_poll), .sample(sample), .do_in(do_in), .ack(ack),
        .word_out(word_out), .word_valid(word_valid), .busy(busy),
        .ready(ready), .dummy_err(dummy_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ready) ready_seen = ready_seen + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one DO bit, let it settle through the synchroniser, then sample it
    task automatic send_bit(input logic b, input logic a);
        do_in = b;
        repeat (SS + 1) tick();
        sample = 1'b1;
        ack = a;
        tick();
        sample = 1'b0;
        ack = 1'b0;
    endtask

    task automatic do_read(input logic dbit, input logic [W-1:0] w, input logic ack_last);
        arm_read = 1'b1;
        tick();
        arm_read = 1'b0;
        check("busy_after_arm", 32'(busy), 32'd1);
        check("derr_cleared_by_arm", 32'(dummy_err), 32'd0);
        send_bit(dbit, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                check("busy_before_last", 32'(busy), 32'd1);
                check("valid_before_last", 32'(word_valid), 32'(exp_valid));
            end
            send_bit(1'((w >> (W - 1 - i)) % 2), (i == W - 1) ? ack_last : 1'b0);
        end
        exp_word  = w;
        exp_valid = 1'b1;
        exp_derr  = dbit;
        check("word_out", 32'(word_out), 32'(exp_word));
        check("word_valid", 32'(word_valid), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("dummy_err", 32'(dummy_err), 32'(exp_derr));
    endtask

    task automatic do_ack;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        exp_valid = 1'b0;
        check("ack_clears_valid", 32'(word_valid), 32'd0);
        check("ack_keeps_word", 32'(word_out), 32'(exp_word));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, 32'(word_out), 32'd0);
        check({tag, "_valid"}, 32'(word_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_derr"}, 32'(dummy_err), 32'd0);
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; arm_read = 1'b0; arm_poll = 1'b0;
        sample = 1'b0; do_in = 1'b0; ack = 1'b0;
        exp_word = '0; exp_valid = 1'b0; exp_derr = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        cs = 1'b1;
        tick();

        // Basic x16 read
        do_read(1'b0, 16'hA55A, 1'b0);

        // Sample while idle is ignored
        do_in = 1'b1;
        repeat (SS + 1) tick();
        sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        check("idle_sample_busy", 32'(busy), 32'd0);
        check("idle_sample_word", 32'(word_out), 32'hA55A);
        do_ack();

        // Dummy bit high
        do_read(1'b1, 16'h1234, 1'b0);
        do_ack();

        // Abort mid-shift
        arm_read = 1'b1;
        tick();
        arm_read = 1'b0;
        exp_derr = 1'b0;
        check("abort_derr_cleared", 32'(dummy_err), 32'd0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        cs = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(word_valid), 32'd0);
        check("abort_word", 32'(word_out), 32'h1234);
        cs = 1'b1;
        tick();
        do_read(1'b0, 16'hFFFF, 1'b0);
        do_ack();

        // Randomized reads
        for (int n = 0; n < 4; n++) begin
            do_read(1'($urandom_range(0, 1)), W'($urandom), 1'b0);
            do_ack();
        end

        // Poll until ready
        do_in = 1'b0;
        repeat (SS + 1) tick();
        arm_poll = 1'b1;
        tick();
        arm_poll = 1'b0;
        check("poll_busy", 32'(busy), 32'd1);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            sample = 1'b1;
            tick();
        end
        sample = 1'b0;
        check("poll_still_busy", 32'(busy), 32'd1);
        do_in = 1'b1;
        repeat (SS + 1) tick();
        sample = 1'b1;
        tick();
        sample = 1'b0;
        check("poll_ready", 32'(ready), 32'd1);
        check("poll_ready_busy", 32'(busy), 32'd0);
        check("poll_ready_tmo", 32'(timeout), 32'd0);
        tick();
        check("poll_ready_pulse_end", 32'(ready), 32'd0);
        check("poll_ready_count", 32'(ready_seen), 32'd1);

        // Poll timeout after exactly PT cycles
        do_in = 1'b0;
        repeat (SS + 1) tick();
        arm_poll = 1'b1;
        tick();
        arm_poll = 1'b0;
        ready_seen = 0;
        repeat (PT - 1) tick();
        check("tmo_not_yet", 32'(timeout), 32'd0);
        check("tmo_busy_before", 32'(busy), 32'd1);
        tick();
        check("tmo_set", 32'(timeout), 32'd1);
        check("tmo_busy_after", 32'(busy), 32'd0);
        tick();
        check("tmo_sticky", 32'(timeout), 32'd1);
        check("tmo_no_ready", 32'(ready_seen), 32'd0);
        arm_poll = 1'b1;
        tick();
        arm_poll = 1'b0;
        check("tmo_cleared_by_arm", 32'(timeout), 32'd0);
        cs = 1'b0;
        tick();
        check("poll_abort_busy", 32'(busy), 32'd0);
        cs = 1'b1;
        tick();

        // Completion wins over same-cycle ack
        do_read(1'b0, 16'h1111, 1'b0);
        do_read(1'b0, 16'h00FF, 1'b1);

        // Reset during SHIFT
        arm_read = 1'b1;
        tick();
        arm_read = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midreset");
        exp_word = '0; exp_valid = 1'b0; exp_derr = 1'b0;
        do_read(1'b0, W'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
